// File: rtl/iterative_multiplier_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iterative_multiplier_pkg: FSM states and step-count helper.          |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package iterative_multiplier_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int steps(input int width, input int bits_per_cycle);
      return width / bits_per_cycle;
   endfunction

endpackage
`default_nettype wire

// File: rtl/iterative_multiplier_partial_product.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | partial_product: unsigned WIDTH x BITS_PER_CYCLE combinational mult. |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module partial_product #(
   parameter int WIDTH          = 24,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [WIDTH-1:0]                i_a,
   input  logic [BITS_PER_CYCLE-1:0]       i_b,
   output logic [WIDTH+BITS_PER_CYCLE-1:0] o_p
);

   localparam int C_PW = WIDTH + BITS_PER_CYCLE;

   always_comb begin
      o_p = C_PW'(i_a) * C_PW'(i_b);
   end

endmodule
`default_nettype wire

// File: rtl/iterative_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iterative_multiplier: unsigned shift-add multiplier, valid/ready I/O.|
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module iterative_multiplier
   import iterative_multiplier_pkg::*;
#(
   parameter int WIDTH          = 24,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_in_valid,
   output logic                 io_in_ready,
   input  logic [WIDTH-1:0]     io_in_a,
   input  logic [WIDTH-1:0]     io_in_b,
   output logic                 io_out_valid,
   input  logic                 io_out_ready,
   output logic [2*WIDTH-1:0]   io_out_s,
   output logic                 io_out_norm,
   output logic                 io_busy
);

   localparam int C_STEPS = steps(WIDTH, BITS_PER_CYCLE);
   localparam int C_CW    = $clog2(C_STEPS + 1);
   localparam int C_PW    = WIDTH + BITS_PER_CYCLE;
   localparam int C_SW    = 2 * WIDTH;

   state_t                      state_q, state_d;
   logic [WIDTH-1:0]            a_q, a_d;
   logic [WIDTH-1:0]            b_q, b_d;
   logic [C_CW-1:0]             cnt_q, cnt_d;
   logic [C_SW-1:0]             acc_q, acc_d;
   logic [C_SW-1:0]             s_q, s_d;
   logic                        norm_q, norm_d;
   logic                        valid_q, valid_d;
   logic                        busy_q, busy_d;

   logic [C_PW-1:0]             w_pp;
   logic [C_SW-1:0]             w_pp_shifted;
   logic [C_SW-1:0]             w_acc_next;
   logic                        w_accept;

   partial_product #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_partial_product (
      .i_a (a_q),
      .i_b (b_q[BITS_PER_CYCLE-1:0]),
      .o_p (w_pp)
   );

   assign w_pp_shifted = C_SW'(w_pp) << (cnt_q * BITS_PER_CYCLE);
   assign w_acc_next   = acc_q + w_pp_shifted;
   assign io_in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && io_out_ready);
   assign w_accept     = io_in_valid && io_in_ready;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      s_d     = s_q;
      norm_d  = norm_q;
      case (state_q)
         ST_RUN: begin
            acc_d = w_acc_next;
            b_d   = b_q >> BITS_PER_CYCLE;
            cnt_d = cnt_q + C_CW'(1);
            if (cnt_q == C_CW'(C_STEPS - 1)) begin
               state_d = ST_DONE;
               s_d     = w_acc_next;
               norm_d  = w_acc_next[C_SW-1];
            end
         end
         ST_DONE: begin
            if (io_out_ready) state_d = ST_IDLE;
         end
         default: ;
      endcase
      // An accept in DONE overrides the return to IDLE: back-to-back start.
      if (w_accept) begin
         state_d = ST_RUN;
         a_d     = io_in_a;
         b_d     = io_in_b;
         acc_d   = '0;
         cnt_d   = '0;
      end
      valid_d = (state_d == ST_DONE);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         s_q     <= '0;
         norm_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         norm_q  <= norm_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign io_out_valid = valid_q;
   assign io_out_s     = s_q;
   assign io_out_norm  = norm_q;
   assign io_busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_iterative_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_iterative_multiplier: randomized bench with behavioural model.    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_iterative_multiplier;

   localparam int W      = 24;
   localparam int STEPS  = 24;
   localparam int W2     = 8;
   localparam int B2     = 4;
   localparam int STEPS2 = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic              reset;
   logic              in_valid, in_ready, out_valid, out_ready, out_norm, busy;
   logic [W-1:0]      in_a, in_b;
   logic [2*W-1:0]    out_s;

   logic              s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_norm, s_busy;
   logic [W2-1:0]     s_in_a, s_in_b;
   logic [2*W2-1:0]   s_out_s;

   iterative_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut (
      .clock (clock), .reset (reset),
      .io_in_valid (in_valid), .io_in_ready (in_ready),
      .io_in_a (in_a), .io_in_b (in_b),
      .io_out_valid (out_valid), .io_out_ready (out_ready),
      .io_out_s (out_s), .io_out_norm (out_norm), .io_busy (busy)
   );

   iterative_multiplier #(.WIDTH(W2), .BITS_PER_CYCLE(B2)) u_dut_small (
      .clock (clock), .reset (reset),
      .io_in_valid (s_in_valid), .io_in_ready (s_in_ready),
      .io_in_a (s_in_a), .io_in_b (s_in_b),
      .io_out_valid (s_out_valid), .io_out_ready (s_out_ready),
      .io_out_s (s_out_s), .io_out_norm (s_out_norm), .io_busy (s_busy)
   );

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Model: an operation is pending for STEPS edges after acceptance, then
   // its product is offered until taken.
   bit          m_has = 1'b0;
   int          m_rem = 0;
   logic [63:0] m_prod = '0;
   bit          m_rdy;

   always @(negedge clock) begin
      if (!reset) begin
         check("rst_valid", 64'(out_valid), 64'd0);
         check("rst_s", 64'(out_s), 64'd0);
         check("rst_norm", 64'(out_norm), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
         check("rst_in_ready", 64'(in_ready), 64'd1);
         m_has = 1'b0;
      end else begin
         m_rdy = !m_has || (m_rem == 0 && out_ready);
         check("model_valid", 64'(out_valid), 64'(m_has && m_rem == 0));
         check("model_busy", 64'(busy), 64'(m_has));
         check("model_in_ready", 64'(in_ready), 64'(m_rdy));
         if (m_has && m_rem == 0) begin
            check("model_product", 64'(out_s), m_prod);
            check("model_norm", 64'(out_norm), 64'(m_prod[2*W-1]));
         end
         if (m_has && m_rem > 0) m_rem--;
         else if (m_has && out_ready) m_has = 1'b0;
         if (m_rdy && in_valid) begin
            m_has  = 1'b1;
            m_rem  = STEPS;
            m_prod = 64'(in_a) * 64'(in_b);
         end
      end
   end

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp, input logic expn, input int hold);
      int n;
      in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clock); #1;
      check("accept_busy", 64'(busy), 64'd1);
      in_valid = 1'b0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clock); #1; n++;
      end
      check("latency", 64'(n), 64'(STEPS));
      check("lit_product", 64'(out_s), exp);
      check("lit_norm", 64'(out_norm), 64'(expn));
      for (int i = 0; i < hold; i++) begin
         @(posedge clock); #1;
         check("hold_s", 64'(out_s), exp);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check("xfer_valid_low", 64'(out_valid), 64'd0);
      check("xfer_idle", 64'(busy), 64'd0);
   endtask

   task automatic back_to_back();
      int acc_cycle [4];
      int k;
      bit rdy;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_a = W'($urandom);
         in_b = W'($urandom);
         in_valid = 1'b1;
         k = 0;
         rdy = 1'b0;
         while (!rdy && k < 100) begin
            @(negedge clock); rdy = in_ready;
            @(posedge clock); #1; k++;
         end
         check("b2b_accepted", 64'(rdy), 64'd1);
         acc_cycle[i] = cycle;
         // DONE lasts one cycle and accepts the next pair: STEPS+1 edges apart.
         if (i > 0) check("b2b_interval", 64'(acc_cycle[i] - acc_cycle[i-1]), 64'(STEPS + 1));
      end
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 100) begin
         @(posedge clock); #1; k++;
      end
      check("b2b_last_latency", 64'(k), 64'(STEPS));
      @(posedge clock); #1;
      out_ready = 1'b0;
      check("b2b_idle", 64'(busy), 64'd0);
   endtask

   task automatic reset_mid_run();
      in_a = 24'hABCDEF; in_b = 24'h000123; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      @(posedge clock); #1;
      check("abort_busy_next", 64'(busy), 64'd0);
      reset = 1'b1;
      do_op(24'd3, 24'd5, 64'd15, 1'b0, 0);
   endtask

   task automatic small_op(input logic [W2-1:0] a, input logic [W2-1:0] b,
                           input logic [63:0] exp, input logic expn);
      int n;
      check("small_in_ready", 64'(s_in_ready), 64'd1);
      s_in_a = a; s_in_b = b; s_in_valid = 1'b1; s_out_ready = 1'b0;
      @(posedge clock); #1;
      s_in_valid = 1'b0;
      s_in_a = W2'($urandom);
      s_in_b = W2'($urandom);
      n = 0;
      while (!s_out_valid && n < 50) begin
         @(posedge clock); #1; n++;
      end
      check("small_latency", 64'(n), 64'(STEPS2));
      check("small_product", 64'(s_out_s), exp);
      check("small_norm", 64'(s_out_norm), 64'(expn));
      s_out_ready = 1'b1;
      @(posedge clock); #1;
      s_out_ready = 1'b0;
      check("small_idle", 64'(s_busy), 64'd0);
   endtask

   initial begin
      logic [W-1:0]  ra, rb;
      logic [W2-1:0] sa, sb;
      logic [63:0]   p;
      reset = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;

      do_op(24'hFFFFFF, 24'hFFFFFF, 64'hFFFFFE000001, 1'b1, 0);
      do_op(24'h800000, 24'h800000, 64'h400000000000, 1'b0, 10);
      do_op(24'h000000, 24'h123456, 64'd0, 1'b0, 2);
      for (int i = 0; i < 6; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (i == 0) ra[W-1] = 1'b1;
         p = 64'(ra) * 64'(rb);
         do_op(ra, rb, p, p[2*W-1], int'($urandom_range(0, 3)));
      end
      back_to_back();
      reset_mid_run();

      small_op(8'hFF, 8'hFF, 64'hFE01, 1'b1);
      for (int i = 0; i < 5; i++) begin
         sa = W2'($urandom);
         sb = W2'($urandom);
         p = 64'(sa) * 64'(sb);
         small_op(sa, sb, p, p[2*W2-1]);
      end

      repeat (2) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
